// File: rtl/csr_hpm_counters.sv
// ---------------------------------------------------------------------------
// csr_hpm_counters
//
// Machine performance-counter unit. It holds mcycle, minstret and N_COUNTERS
// programmable HPM counters (mhpmcounter3..), with their mhpmevent selectors
// and mcountinhibit. It sits beside the core CSR file, and that file muxes
// rdata in whenever hit is high.
//
// Ports:
//   clock     single clock; all state updates on the rising edge
//   reset     synchronous, active-high reset
//   halt      core halted; mcycle does not count while high
//   instret   one instruction retired this cycle
//   events    event strobes; bit k is event code k+1
//   wen       CSR write strobe
//   ren       CSR read strobe (used only when the snapshot build is enabled)
//   addr      CSR address
//   wdata     CSR write data
//   rdata     CSR read data, combinational from addr and current state
//   hit       addr decodes to a register of this block
//   overflow  sticky wrap flags: bit0 mcycle, bit1 minstret, bit 2+i HPM i
//
// Build option:
//   CSR_HPM_SNAPSHOT_EN  When defined, a read of a counter's low half latches
//                        that counter's upper half into a shadow register.
//                        A later high-half read returns the shadow, so a
//                        32-bit core gets a 64-bit value that cannot tear.
//
// Counter slot numbering: slot 0 is mcycle, slot 1 is minstret and slot 2+i
// is HPM i. The CSR index of a slot (address offset and mcountinhibit bit)
// is 0 for slot 0 and slot+1 otherwise, because index 1 (time) lives
// elsewhere.
// ---------------------------------------------------------------------------
module csr_hpm_counters #(
  parameter int N_EVENTS   = 8,
  parameter int N_COUNTERS = 4,
  parameter int CNT_W      = 64,
  parameter int EVW        = $clog2(N_EVENTS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  instret,
  input  logic [N_EVENTS-1:0]   events,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [11:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  hit,
  output logic [N_COUNTERS+1:0] overflow
);

  localparam int NC = N_COUNTERS + 2;
  localparam int HW = CNT_W - 32;

  localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;
  localparam logic [11:0] MHPMEVENT3_ADDR    = 12'h323;

  // Implemented mcountinhibit bits: CY (0), IR (2) and HPM bits 3..2+N_COUNTERS.
  // The span is computed at 33 bits so that N_COUNTERS=29 does not overflow.
  localparam logic [32:0] INH_SPAN = (33'd1 << (3 + N_COUNTERS)) - 33'd1;
  localparam logic [31:0] INH_MASK = INH_SPAN[31:0] & ~32'h0000_0002;

  function automatic logic [11:0] slot_csr_idx(input int k);
    return (k == 0) ? 12'd0 : 12'(k + 1);
  endfunction

  logic [31:0]      inhibit_reg;
  logic [NC-1:0]    inc_req;
  logic [CNT_W-1:0] cnt_q   [NC];
  logic [HW-1:0]    hi_view [NC];
  logic [EVW-1:0]   evsel_q [N_COUNTERS];

`ifndef CSR_HPM_SNAPSHOT_EN
  // ren has no function without the snapshot shadows.
  logic unused_ren;
  assign unused_ren = ren;
`endif

  // -------------------------------------------------------------------------
  // mcountinhibit. Unimplemented bits are masked at write time, so they
  // always read back as zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      inhibit_reg <= '0;
    end else if (wen && addr == MCOUNTINHIBIT_ADDR) begin
      inhibit_reg <= wdata & INH_MASK;
    end
  end

  assign inc_req[0] = ~halt;
  assign inc_req[1] = instret;

  // -------------------------------------------------------------------------
  // mhpmevent selectors and their event match. Codes 0 and above N_EVENTS
  // match nothing, but the stored code is still read back as written.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_COUNTERS; gi++) begin : g_evsel
      localparam logic [11:0] EV_ADDR = MHPMEVENT3_ADDR + 12'(gi);

      logic [EVW-1:0] evsel_reg;
      logic           ev_match;

      always_ff @(posedge clock) begin
        if (reset) begin
          evsel_reg <= '0;
        end else if (wen && addr == EV_ADDR) begin
          evsel_reg <= wdata[EVW-1:0];
        end
      end

      always_comb begin
        ev_match = 1'b0;
        for (int e = 0; e < N_EVENTS; e++) begin
          if (evsel_reg == EVW'(e + 1)) begin
            ev_match = events[e];
          end
        end
      end

      assign evsel_q[gi]     = evsel_reg;
      assign inc_req[2 + gi] = ev_match;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Counter slots: half-word writes, increment, sticky overflow and the
  // optional high-half shadow.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_cnt
      localparam int          CIDX    = (gi == 0) ? 0 : gi + 1;
      localparam logic [11:0] LO_ADDR = 12'hB00 + 12'(CIDX);
      localparam logic [11:0] HI_ADDR = 12'hB80 + 12'(CIDX);

      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             ovf_reg;
      logic             ovf_next;
      logic             lo_wr;
      logic             hi_wr;
      logic             inc_en;

      assign lo_wr  = wen && (addr == LO_ADDR);
      assign hi_wr  = wen && (addr == HI_ADDR);
      // Gated by the inhibit value held before any write in this cycle.
      assign inc_en = inc_req[gi] && !inhibit_reg[CIDX];

      // A write beats the increment; the written value lands untouched.
      always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (lo_wr) begin
          cnt_next = {cnt_reg[CNT_W-1:32], wdata};
          ovf_next = 1'b0;
        end else if (hi_wr) begin
          cnt_next = {wdata[HW-1:0], cnt_reg[31:0]};
          ovf_next = 1'b0;
        end else if (inc_en) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (&cnt_reg) begin
            ovf_next = 1'b1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          ovf_reg <= ovf_next;
        end
      end

`ifdef CSR_HPM_SNAPSHOT_EN
      logic [HW-1:0] shadow_reg;

      // A write reloads the shadow with the new upper half. Otherwise a
      // low-half read captures the upper half that goes with the low
      // word being returned in this same cycle.
      always_ff @(posedge clock) begin
        if (reset) begin
          shadow_reg <= '0;
        end else if (lo_wr || hi_wr) begin
          shadow_reg <= cnt_next[CNT_W-1:32];
        end else if (ren && addr == LO_ADDR) begin
          shadow_reg <= cnt_reg[CNT_W-1:32];
        end
      end

      assign hi_view[gi] = shadow_reg;
`else
      assign hi_view[gi] = cnt_reg[CNT_W-1:32];
`endif

      assign cnt_q[gi]    = cnt_reg;
      assign overflow[gi] = ovf_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read mux. Anything not decoded here, including HPM indices at or beyond
  // N_COUNTERS, leaves hit low and rdata at zero.
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    if (addr == MCOUNTINHIBIT_ADDR) begin
      hit   = 1'b1;
      rdata = inhibit_reg;
    end
    for (int k = 0; k < NC; k++) begin
      if (addr == 12'hB00 + slot_csr_idx(k)) begin
        hit   = 1'b1;
        rdata = cnt_q[k][31:0];
      end
      if (addr == 12'hB80 + slot_csr_idx(k)) begin
        hit   = 1'b1;
        rdata = 32'(hi_view[k]);
      end
    end
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (addr == MHPMEVENT3_ADDR + 12'(i)) begin
        hit   = 1'b1;
        rdata = 32'(evsel_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_csr_hpm_counters.sv
// ---------------------------------------------------------------------------
// tb_csr_hpm_counters
//
// Directed bench for csr_hpm_counters with the default parameters
// (N_EVENTS=8, N_COUNTERS=4, CNT_W=64). Each step drives inputs just after a
// rising edge and checks state a little later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_csr_hpm_counters;

  logic        clock;
  logic        reset;
  logic        halt;
  logic        instret;
  logic [7:0]  events;
  logic        wen;
  logic        ren;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic [5:0]  overflow;

  int vectors     = 0;
  int miscompares = 0;

  csr_hpm_counters dut (
    .clock    (clock),
    .reset    (reset),
    .halt     (halt),
    .instret  (instret),
    .events   (events),
    .wen      (wen),
    .ren      (ren),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .hit      (hit),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational read: rdata and hit are both compared.
  task automatic rd(input logic [11:0] a, input string tag,
                    input logic [31:0] exp_data, input logic exp_hit);
    addr = a;
    #1;
    check({tag, " rdata"}, rdata, exp_data);
    check({tag, " hit"}, {31'd0, hit}, {31'd0, exp_hit});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    halt    = 1'b0;
    instret = 1'b0;
    events  = '0;
    wen     = 1'b0;
    ren     = 1'b0;
    addr    = '0;
    wdata   = '0;

    // Reset state
    tick();
    tick();
    rd(12'h000, "reset addr0", 32'h0, 1'b0);
    check("reset overflow", 32'(overflow), 32'h0);

    // 10 free-running cycles
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    halt = 1'b1;
    rd(12'hB00, "mcycle after 10", 32'd10, 1'b1);
    rd(12'hB80, "mcycle hi", 32'd0, 1'b1);
    rd(12'hB02, "minstret idle", 32'd0, 1'b1);
    rd(12'hB03, "hpm3 idle", 32'd0, 1'b1);
    rd(12'hB06, "hpm6 idle", 32'd0, 1'b1);
    check("overflow idle", 32'(overflow), 32'h0);

    // Event selection
    wr(12'h323, 32'd3);
    wr(12'h324, 32'd1);
    wr(12'h325, 32'd3);
    rd(12'h323, "mhpmevent3", 32'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin events = 8'h04; tick(); end
    for (int i = 0; i < 4; i++) begin events = 8'h01; tick(); end
    events = '0;
    rd(12'hB03, "hpm3 code3", 32'd5, 1'b1);
    rd(12'hB04, "hpm4 code1", 32'd4, 1'b1);
    rd(12'hB05, "hpm5 code3", 32'd5, 1'b1);
    rd(12'hB06, "hpm6 code0", 32'd0, 1'b1);

    // Code 9 is out of range: stored, read back, never counts
    wr(12'h323, 32'd9);
    rd(12'h323, "mhpmevent3 code9", 32'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin events = 8'hFF; tick(); end
    events = '0;
    rd(12'hB03, "hpm3 code9 frozen", 32'd5, 1'b1);
    rd(12'hB04, "hpm4 all events", 32'd7, 1'b1);
    rd(12'hB05, "hpm5 all events", 32'd8, 1'b1);
    rd(12'hB06, "hpm6 still 0", 32'd0, 1'b1);

    // mcountinhibit: the write cycle still counts with the old value
    halt    = 1'b0;
    instret = 1'b1;
    wr(12'h320, 32'h5);
    rd(12'h320, "mcountinhibit", 32'h5, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    rd(12'hB00, "mcycle inhibited", 32'd11, 1'b1);
    rd(12'hB02, "minstret inhibited", 32'd1, 1'b1);
    wr(12'h320, 32'h0);
    rd(12'hB00, "mcycle at uninhibit", 32'd11, 1'b1);
    rd(12'hB02, "minstret at uninhibit", 32'd1, 1'b1);
    tick();
    rd(12'hB00, "mcycle resumed", 32'd12, 1'b1);
    rd(12'hB02, "minstret resumed", 32'd2, 1'b1);
    halt    = 1'b1;
    instret = 1'b0;
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, "mcountinhibit mask", 32'h0000_007D, 1'b1);
    wr(12'h320, 32'h0);

    // mcycle wrap and sticky overflow
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    rd(12'hB00, "mcycle written lo", 32'hFFFF_FFFE, 1'b1);
    rd(12'hB80, "mcycle written hi", 32'hFFFF_FFFF, 1'b1);
    halt = 1'b0;
    tick();
    tick();
    halt = 1'b1;
    rd(12'hB00, "mcycle wrapped lo", 32'h0, 1'b1);
    rd(12'hB80, "mcycle wrapped hi", 32'h0, 1'b1);
    check("overflow after wrap", 32'(overflow), 32'h1);
    wr(12'hB00, 32'h0);
    check("overflow cleared", 32'(overflow), 32'h0);

    // Write beats a coincident increment
    wr(12'h323, 32'd3);
    rd(12'hB03, "hpm3 before write", 32'd5, 1'b1);
    addr   = 12'hB03;
    wdata  = 32'h100;
    wen    = 1'b1;
    events = 8'h04;
    tick();
    wen    = 1'b0;
    events = '0;
    rd(12'hB03, "hpm3 write priority", 32'h100, 1'b1);
    rd(12'hB05, "hpm5 same-cycle event", 32'd9, 1'b1);
    rd(12'hB04, "hpm4 not selected", 32'd7, 1'b1);
    wr(12'hB83, 32'h1234_5678);
    rd(12'hB83, "hpm3 hi write", 32'h1234_5678, 1'b1);
    rd(12'hB03, "hpm3 lo kept", 32'h100, 1'b1);

    // Unmapped addresses
    rd(12'hB20, "unmapped B20", 32'h0, 1'b0);
    rd(12'hB07, "unmapped hpm index 4", 32'h0, 1'b0);
    rd(12'hB01, "unmapped B01", 32'h0, 1'b0);
    rd(12'h327, "unmapped mhpmevent7", 32'h0, 1'b0);

    // High half read after low-half read across a carry
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFF);
    addr = 12'hB00;
    ren  = 1'b1;
    halt = 1'b0;
    tick();
    halt = 1'b1;
    ren  = 1'b0;
`ifdef CSR_HPM_SNAPSHOT_EN
    rd(12'hB80, "mcycle hi snapshot", 32'h0, 1'b1);
`else
    rd(12'hB80, "mcycle hi live", 32'h1, 1'b1);
`endif
    rd(12'hB00, "mcycle lo after carry", 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
